serial_transceiver: RTL and testbench
=====================================

# serial_transceiver

Full-duplex asynchronous serial transceiver that replaces the fixed 8-bit, fixed-rate shift-register link between the Nios II parallel PIO ports and the board serial pins. Data width, bit period and parity are parameters. Transmit and receive run concurrently with independent state machines. The receiver samples at mid-bit through a synchroniser, and both sides use valid/ready handshakes instead of free-running counters.

## Interface
- DATA_W, 8: payload bits per frame; legal range 5..16.
- CLKS_PER_BIT, 8192: CLOCK_50 cycles per serial bit; must be even and ≥ 4.
- PARITY_EN, 0: 1 inserts one parity bit after the payload.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
- CLOCK_50  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- tx_data  in  DATA_W  payload to send; sampled only in the accept cycle.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  transmitter idle; accept occurs when tx_valid && tx_ready.
- tx_busy  out  1  frame in progress on serial_out.
- serial_out  out  1  line output; idle high.
- serial_in  in  1  line input, asynchronous to CLOCK_50.
- rx_data  out  DATA_W  last received payload; held until the next rx_valid.
- rx_valid  out  1  one-cycle pulse when a frame completes.
- rx_parity_err  out  1  parity mismatch on the frame flagged by rx_valid; held with rx_data.
- rx_frame_err  out  1  stop bit sampled as 0; held with rx_data.
- rx_busy  out  1  receive frame in progress.

## Operation
- Frame format: start bit 0, then DATA_W payload bits LSB first, then an optional parity bit, then one stop bit 1.
- Values during reset:
  - serial_out=1; tx_ready=0; tx_busy=0.
  - rx_valid=0; rx_data=0; both error flags 0; rx_busy=0; synchroniser flops=1.
- TX FSM states: IDLE → START → DATA → (PARITY if PARITY_EN) → STOP → IDLE.
  - tx_ready=1 only in IDLE.
  - On accept, tx_data is latched and parity is computed from it.
  - tx_valid while not in IDLE is ignored; it is not queued.
- RX path: serial_in passes through a 2-flop synchroniser.
- RX FSM states: IDLE → START → DATA → (PARITY) → STOP → IDLE.
  - IDLE leaves to START on the first synchronised 0.
  - START re-samples after CLKS_PER_BIT/2 cycles. If the sample is 1, the start was false: return to IDLE with no flags.
  - Each following bit is sampled CLKS_PER_BIT cycles after the previous sample.
  - At the stop sample, rx_data and both error flags are updated and rx_valid pulses, including when rx_frame_err=1.
  - The FSM then returns to IDLE immediately, giving half a bit of tolerance before the next start.
- TX and RX are fully independent. Loopback (serial_out tied to serial_in) is legal.
- Reset asserted mid-frame: the frame is aborted, serial_out goes to 1 asynchronously, the partial RX frame is discarded, and no rx_valid is produced.

## Timing
- Accept edge at cycle a:
  - serial_out=0 from a+1.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - tx_busy is high from a+1 through the end of the stop bit.
  - tx_ready returns at a+1+(DATA_W+PARITY_EN+2)·CLKS_PER_BIT.
  - Back-to-back frames are legal: tx_valid held high gives no idle gap beyond that one accept cycle.
- RX timing, with t0 = the first cycle the FSM sees the synchronised 0 (2 cycles after the pin falls):
  - Start check at t0+CLKS_PER_BIT/2.
  - Bit k (k=0 is the payload LSB) sampled at t0+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT.
  - rx_valid is high in the cycle after the stop sample.
- Bit timer width: $clog2(CLKS_PER_BIT). Bit index width: $clog2(DATA_W+1). No counter may wrap mid-bit.

## Structure
- Package serial_pkg holds:
  - tx_state_t and rx_state_t enums;
  - a parity function (reduction XOR with odd/even select);
  - parameter legality checks as localparams.
- Sub-module bit_timer, instantiated once for TX and once for RX:
  - inputs: load, half (load CLKS_PER_BIT/2 instead of CLKS_PER_BIT);
  - output: tick, a one-cycle pulse when the count expires.

## Test plan
- Loopback, DATA_W=8, CLKS_PER_BIT=16, no parity; send 8'hA5 → rx_valid once with rx_data=8'hA5 and no errors. serial_out pattern: 0,1,0,1,0,0,1,0,1,1, each held 16 cycles.
- PARITY_EN=1, PARITY_ODD=1, loopback 8'h03 → parity bit 1, no error. Force the parity bit to 0 on the line → rx_parity_err=1 with rx_data=8'h03.
- Drive serial_in low for 6 cycles with CLKS_PER_BIT=16 → false start: RX returns to IDLE, no rx_valid.
- Drive a frame with stop bit 0 → rx_valid pulses with rx_frame_err=1.
- tx_valid held high with a 3-word sequence → three contiguous frames; tx_ready high for exactly one cycle between frames; tx_valid while busy is ignored.
- Assert reset at mid-payload of both TX and RX → serial_out=1 in the same cycle; no rx_valid; after release, a 9-bit frame (DATA_W=9, 9'h1FF) loops back correctly.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial transceiver.
//   tx_state_t / rx_state_t : frame sequencing states for each direction
//   DATA_W_MIN/MAX, CLKS_PER_BIT_MIN : legal parameter limits
//   params_legal()           : elaboration-time parameter check
//   parity_bit()             : parity bit for a payload (even or odd)
package serial_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam int unsigned DATA_W_MIN       = 5;
  localparam int unsigned DATA_W_MAX       = 16;
  localparam int unsigned CLKS_PER_BIT_MIN = 4;

  function automatic bit params_legal(input int unsigned data_w,
                                      input int unsigned clks_per_bit,
                                      input int unsigned parity_en,
                                      input int unsigned parity_odd);
    return (data_w >= DATA_W_MIN) && (data_w <= DATA_W_MAX) &&
           (clks_per_bit >= CLKS_PER_BIT_MIN) && (clks_per_bit % 2 == 0) &&
           (parity_en <= 1) && (parity_odd <= 1);
  endfunction

  // Payload is zero-extended by the caller; padding zeros do not change the XOR.
  function automatic logic parity_bit(input logic [DATA_W_MAX-1:0] data,
                                      input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period down-counter shared by the TX and RX sequencers.
//   clk_i, rst_i : clock and asynchronous active-high reset
//   load_i       : restart the count (takes priority over expiry)
//   half_i       : with load_i, count half a bit instead of a full bit
//   tick_o       : one-cycle pulse in the last cycle of the loaded period
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 8192
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic half_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  // run_q keeps the expired counter from ticking repeatedly while parked at 0.
  assign tick_o = run_q && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (load_i) begin
      cnt_d = half_i ? HALF_M1 : FULL_M1;
      run_d = 1'b1;
    end else if (tick_o) begin
      run_d = 1'b0;
    end else if (run_q) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/serial_transceiver.sv
// Full-duplex asynchronous serial transceiver (start, DATA_W bits LSB first,
// optional parity, one stop bit). TX and RX run independently.
//   CLOCK_50, reset          : clock, asynchronous active-high reset
//   tx_data/tx_valid/tx_ready: transmit handshake; accept on valid && ready
//   tx_busy, serial_out      : frame in progress, line output (idle high)
//   serial_in                : asynchronous line input
//   rx_data, rx_valid        : received payload and its one-cycle strobe
//   rx_parity_err/frame_err  : status of the frame flagged by rx_valid
//   rx_busy                  : receive frame in progress
module serial_transceiver
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 8192,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              serial_out,
  input  logic              serial_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_parity_err,
  output logic              rx_frame_err,
  output logic              rx_busy
);

  localparam bit PARAMS_OK = params_legal(DATA_W, CLKS_PER_BIT, PARITY_EN, PARITY_ODD);
  if (!PARAMS_OK) begin : g_bad_params
    $error("serial_transceiver: illegal parameter set");
  end

  localparam bit   PAR_EN  = (PARITY_EN != 0);
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  localparam int unsigned IDX_W = $clog2(DATA_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  // Holds tx_ready low for the first cycle after reset as well as during it.
  logic en_q;
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) en_q <= 1'b0;
    else       en_q <= 1'b1;
  end

  // ---------------------------------------------------------------- transmit
  tx_state_t         tx_state_q, tx_state_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [IDX_W-1:0]  tx_idx_q, tx_idx_d;
  logic              tx_par_q, tx_par_d;
  logic              tx_line_q, tx_line_d;
  logic              tx_load, tx_tick;

  assign tx_ready   = (tx_state_q == TX_IDLE) && en_q;
  assign tx_busy    = (tx_state_q != TX_IDLE);
  assign serial_out = tx_line_q;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk_i (CLOCK_50),
    .rst_i (reset),
    .load_i(tx_load),
    .half_i(1'b0),
    .tick_o(tx_tick)
  );

  // The line level is registered alongside the state so serial_out never
  // glitches while the state decode changes.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_idx_d   = tx_idx_q;
    tx_par_d   = tx_par_q;
    tx_line_d  = tx_line_q;
    tx_load    = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid && tx_ready) begin
          tx_shift_d = tx_data;
          tx_par_d   = parity_bit(DATA_W_MAX'(tx_data), PAR_ODD);
          tx_line_d  = 1'b0;
          tx_load    = 1'b1;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_line_d  = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
          tx_idx_d   = '0;
          tx_load    = 1'b1;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          tx_load = 1'b1;
          if (tx_idx_q == LAST_IDX) begin
            if (PAR_EN) begin
              tx_line_d  = tx_par_q;
              tx_state_d = TX_PARITY;
            end else begin
              tx_line_d  = 1'b1;
              tx_state_d = TX_STOP;
            end
          end else begin
            tx_line_d  = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
            tx_idx_d   = tx_idx_q + 1'b1;
          end
        end
      end
      TX_PARITY: begin
        if (tx_tick) begin
          tx_line_d  = 1'b1;
          tx_load    = 1'b1;
          tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_tick) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '0;
      tx_idx_q   <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_idx_q   <= tx_idx_d;
      tx_par_q   <= tx_par_d;
      tx_line_q  <= tx_line_d;
    end
  end

  // ----------------------------------------------------------------- receive
  logic [1:0]        sync_q;
  logic              rx_s;
  rx_state_t         rx_state_q, rx_state_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [IDX_W-1:0]  rx_idx_q, rx_idx_d;
  logic              rx_par_q, rx_par_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_perr_q, rx_perr_d;
  logic              rx_ferr_q, rx_ferr_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_load, rx_half, rx_tick;

  assign rx_s          = sync_q[1];
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_busy       = (rx_state_q != RX_IDLE);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], serial_in};
  end

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk_i (CLOCK_50),
    .rst_i (reset),
    .load_i(rx_load),
    .half_i(rx_half),
    .tick_o(rx_tick)
  );

  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_idx_d   = rx_idx_q;
    rx_par_d   = rx_par_q;
    rx_data_d  = rx_data_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_valid_d = 1'b0;
    rx_load    = 1'b0;
    rx_half    = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_load    = 1'b1;
          rx_half    = 1'b1;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_tick) begin
          if (rx_s) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_idx_d   = '0;
            rx_load    = 1'b1;
            rx_state_d = RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          // LSB arrives first, so shift in from the top.
          rx_shift_d = {rx_s, rx_shift_q[DATA_W-1:1]};
          rx_load    = 1'b1;
          if (rx_idx_q == LAST_IDX) rx_state_d = PAR_EN ? RX_PARITY : RX_STOP;
          else                      rx_idx_d   = rx_idx_q + 1'b1;
        end
      end
      RX_PARITY: begin
        if (rx_tick) begin
          rx_par_d   = rx_s;
          rx_load    = 1'b1;
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        // Back to IDLE at mid stop bit, leaving half a bit of slack for the
        // next start edge.
        if (rx_tick) begin
          rx_data_d  = rx_shift_q;
          rx_perr_d  = PAR_EN && (rx_par_q != parity_bit(DATA_W_MAX'(rx_shift_q), PAR_ODD));
          rx_ferr_d  = !rx_s;
          rx_valid_d = 1'b1;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_shift_q <= '0;
      rx_idx_q   <= '0;
      rx_par_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_idx_q   <= rx_idx_d;
      rx_par_q   <= rx_par_d;
      rx_data_q  <= rx_data_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_valid_q <= rx_valid_d;
    end
  end

endmodule

// File: tb/tb_serial_transceiver.sv
// Directed bench for serial_transceiver with three instances:
//   u_a : DATA_W=8, no parity     (loopback or hand-driven line)
//   u_b : DATA_W=8, odd parity    (loopback or hand-driven line)
//   u_c : DATA_W=9, no parity     (permanent loopback)
module tb_serial_transceiver;

  localparam int CPB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic       rst_a, txv_a, rdy_a, busy_a, so_a, si_a, rxv_a, pe_a, fe_a, rbusy_a, loop_a, drv_a;
  logic [7:0] txd_a, rxd_a;
  logic       rst_b, txv_b, rdy_b, busy_b, so_b, si_b, rxv_b, pe_b, fe_b, rbusy_b, loop_b, drv_b;
  logic [7:0] txd_b, rxd_b;
  logic       rst_c, txv_c, rdy_c, busy_c, so_c, rxv_c, pe_c, fe_c, rbusy_c;
  logic [8:0] txd_c, rxd_c;

  assign si_a = loop_a ? so_a : drv_a;
  assign si_b = loop_b ? so_b : drv_b;

  serial_transceiver #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) u_a (
    .CLOCK_50(clk), .reset(rst_a), .tx_data(txd_a), .tx_valid(txv_a), .tx_ready(rdy_a),
    .tx_busy(busy_a), .serial_out(so_a), .serial_in(si_a), .rx_data(rxd_a), .rx_valid(rxv_a),
    .rx_parity_err(pe_a), .rx_frame_err(fe_a), .rx_busy(rbusy_a));

  serial_transceiver #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) u_b (
    .CLOCK_50(clk), .reset(rst_b), .tx_data(txd_b), .tx_valid(txv_b), .tx_ready(rdy_b),
    .tx_busy(busy_b), .serial_out(so_b), .serial_in(si_b), .rx_data(rxd_b), .rx_valid(rxv_b),
    .rx_parity_err(pe_b), .rx_frame_err(fe_b), .rx_busy(rbusy_b));

  serial_transceiver #(.DATA_W(9), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) u_c (
    .CLOCK_50(clk), .reset(rst_c), .tx_data(txd_c), .tx_valid(txv_c), .tx_ready(rdy_c),
    .tx_busy(busy_c), .serial_out(so_c), .serial_in(so_c), .rx_data(rxd_c), .rx_valid(rxv_c),
    .rx_parity_err(pe_c), .rx_frame_err(fe_c), .rx_busy(rbusy_c));

  // Received-frame logs: {frame_err, parity_err, payload zero-extended to 16}.
  logic [17:0] log_a[$];
  logic [17:0] log_b[$];
  logic [17:0] log_c[$];
  always @(posedge clk) begin
    if (rxv_a) log_a.push_back({fe_a, pe_a, 8'h00, rxd_a});
    if (rxv_b) log_b.push_back({fe_b, pe_b, 8'h00, rxd_b});
    if (rxv_c) log_c.push_back({fe_c, pe_c, 7'h00, rxd_c});
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;    // expected line bits for u_a, bit 0 = start bit
    logic       par_odd;  // expected parity bit on u_b's line
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] words[3];
  int         acc[3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ((which == 0 && rdy_a) || (which == 1 && rdy_b) || (which == 2 && rdy_c)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout dut%0d: tx_ready stayed 0, expected 1", which);
    end
  endtask

  // Drives n line bits (bit 0 first), CPB cycles each, then idles high.
  task automatic drive_line(input int which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (which == 0) drv_a = bits[i];
      else            drv_b = bits[i];
      repeat (CPB) @(negedge clk);
    end
    drv_a = 1'b1;
    drv_b = 1'b1;
  endtask

  task automatic run_vec_a(input vec_t v);
    bit ok;
    int n0;
    wait_ready(0, ok);
    n0 = log_a.size();
    txd_a = v.data;
    txv_a = 1'b1;
    @(posedge clk);
    #1 txv_a = 1'b0;
    repeat (9) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("a_%02h_bit%0d", v.data, i), so_a, v.frame[i]);
      if (i < 9) repeat (CPB) @(negedge clk);
    end
    repeat (7) @(negedge clk);
    chk($sformatf("a_%02h_ready_early", v.data), rdy_a, 1'b0);
    @(negedge clk);
    chk($sformatf("a_%02h_ready_back", v.data), rdy_a, 1'b1);
    chk($sformatf("a_%02h_busy_end", v.data), busy_a, 1'b0);
    chk($sformatf("a_%02h_rx_count", v.data), log_a.size(), n0 + 1);
    chk($sformatf("a_%02h_rx_entry", v.data), log_a[n0], {2'b00, 8'h00, v.data});
  endtask

  task automatic run_vec_b(input vec_t v);
    bit ok;
    int n0;
    wait_ready(1, ok);
    n0 = log_b.size();
    txd_b = v.data;
    txv_b = 1'b1;
    @(posedge clk);
    #1 txv_b = 1'b0;
    repeat (9 + 9 * CPB) @(negedge clk);
    chk($sformatf("b_%02h_parity_bit", v.data), so_b, v.par_odd);
    repeat (23) @(negedge clk);
    chk($sformatf("b_%02h_ready_early", v.data), rdy_b, 1'b0);
    @(negedge clk);
    chk($sformatf("b_%02h_ready_back", v.data), rdy_b, 1'b1);
    chk($sformatf("b_%02h_rx_count", v.data), log_b.size(), n0 + 1);
    chk($sformatf("b_%02h_rx_entry", v.data), log_b[n0], {2'b00, 8'h00, v.data});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n0;

    vecs[0] = '{8'hA5, 10'b1_10100101_0, 1'b1};
    vecs[1] = '{8'h03, 10'b1_00000011_0, 1'b1};
    vecs[2] = '{8'h01, 10'b1_00000001_0, 1'b0};
    vecs[3] = '{8'h7F, 10'b1_01111111_0, 1'b0};
    vecs[4] = '{8'hFF, 10'b1_11111111_0, 1'b1};
    vecs[5] = '{8'h00, 10'b1_00000000_0, 1'b1};
    words[0] = 8'h3C;
    words[1] = 8'hC3;
    words[2] = 8'h81;

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    txv_a = 1'b0; txv_b = 1'b0; txv_c = 1'b0;
    txd_a = '0;   txd_b = '0;   txd_c = '0;
    loop_a = 1'b1; loop_b = 1'b1;
    drv_a = 1'b1;  drv_b = 1'b1;

    // Values held during reset.
    repeat (3) @(negedge clk);
    chk("rst_serial_out", so_a, 1'b1);
    chk("rst_tx_ready", rdy_a, 1'b0);
    chk("rst_tx_busy", busy_a, 1'b0);
    chk("rst_rx_valid", rxv_a, 1'b0);
    chk("rst_rx_data", rxd_a, 8'h00);
    chk("rst_errs", {pe_a, fe_a}, 2'b00);
    chk("rst_rx_busy", rbusy_a, 1'b0);
    chk("rst_b_outputs", {so_b, rdy_b, busy_b, rbusy_b, rxv_b}, 5'b10000);
    chk("rst_c_outputs", {so_c, rdy_c, busy_c, rbusy_c, rxv_c}, 5'b10000);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven loopback frames.
    for (int i = 0; i < 6; i++) run_vec_a(vecs[i]);
    for (int i = 0; i < 6; i++) run_vec_b(vecs[i]);

    // False start: line low for 6 cycles only.
    loop_a = 1'b0;
    repeat (40) @(negedge clk);
    n0 = log_a.size();
    drv_a = 1'b0;
    repeat (6) @(negedge clk);
    drv_a = 1'b1;
    repeat (4) @(negedge clk);
    chk("false_start_busy", rbusy_a, 1'b1);
    repeat (10) @(negedge clk);
    chk("false_start_idle", rbusy_a, 1'b0);
    chk("false_start_no_valid", log_a.size(), n0);

    // Frame with stop bit 0.
    repeat (20) @(negedge clk);
    n0 = log_a.size();
    drive_line(0, {6'b0, 1'b0, 8'h5A, 1'b0}, 10);
    repeat (40) @(negedge clk);
    chk("frame_err_count", log_a.size(), n0 + 1);
    chk("frame_err_entry", log_a[n0], {2'b10, 16'h005A});
    loop_a = 1'b1;

    // Odd-parity frame for 8'h03 with the parity bit forced to 0.
    loop_b = 1'b0;
    repeat (20) @(negedge clk);
    n0 = log_b.size();
    drive_line(1, {5'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
    repeat (20) @(negedge clk);
    chk("parity_err_count", log_b.size(), n0 + 1);
    chk("parity_err_entry", log_b[n0], {2'b01, 16'h0003});
    loop_b = 1'b1;

    // Back-to-back frames with tx_valid held high.
    repeat (20) @(negedge clk);
    n0 = log_a.size();
    for (int k = 0; k < 3; k++) begin
      wait_ready(0, ok);
      acc[k] = cyc;
      txd_a = words[k];
      txv_a = 1'b1;
      @(posedge clk);
      #1;
      if (k < 2) begin
        @(negedge clk);
        chk($sformatf("b2b_ready_drop%0d", k), rdy_a, 1'b0);
      end
    end
    txv_a = 1'b0;
    chk("b2b_gap01", acc[1] - acc[0], 161);
    chk("b2b_gap12", acc[2] - acc[1], 161);
    wait_ready(0, ok);
    repeat (4) @(negedge clk);
    chk("b2b_rx_count", log_a.size(), n0 + 3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("b2b_rx_word%0d", k), log_a[n0 + k], {2'b00, 8'h00, words[k]});

    // Reset mid-frame on the 9-bit instance, then a clean 9'h1FF frame.
    wait_ready(2, ok);
    n0 = log_c.size();
    txd_c = 9'h0AA;
    txv_c = 1'b1;
    @(posedge clk);
    #1 txv_c = 1'b0;
    repeat (5 * CPB) @(negedge clk);
    chk("midrst_busy_before", {busy_c, rbusy_c}, 2'b11);
    rst_c = 1'b1;
    #1;
    chk("midrst_serial_out", so_c, 1'b1);
    chk("midrst_busy_during", {busy_c, rbusy_c, rdy_c}, 3'b000);
    repeat (3) @(negedge clk);
    rst_c = 1'b0;
    repeat (250) @(negedge clk);
    chk("midrst_no_valid", log_c.size(), n0);
    wait_ready(2, ok);
    txd_c = 9'h1FF;
    txv_c = 1'b1;
    @(posedge clk);
    #1 txv_c = 1'b0;
    wait_ready(2, ok);
    chk("w9_rx_count", log_c.size(), n0 + 1);
    chk("w9_rx_entry", log_c[n0], {2'b00, 16'h01FF});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
